fifo_dpram: RTL and testbench

- Simple dual-port synchronous RAM used as the storage element of single-clock FIFOs.
- Port A is write-capable with a registered readback; port B is read-only with a registered output.
- The FIFO controller drives addra with its write pointer and addrb with its next-read pointer (pre-registered), so dob presents the head-of-FIFO word in the cycle after the pointer update.
- Write-first bypass on port B is required so that a word written into an empty FIFO is visible on dob one cycle later.

---
 rtl/fifo_dpram.sv | 78 +++++++
 tb/tb_fifo_dpram.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fifo_dpram.sv
// ----------------------------------------------------------------------------
// fifo_dpram
//
// Simple dual-port synchronous RAM that stores the words of a single-clock
// FIFO.
//
// Port A writes and reads back through a register. Port B is read-only
// through a register. The FIFO controller drives addra with its write pointer.
// It drives addrb with its next-read pointer before that pointer is
// registered, so dob holds the head-of-FIFO word in the cycle after the
// pointer update.
//
// Ports
//   clk     in   1           single clock, rising-edge active
//   resetb  in   1           synchronous, active-low reset
//   wea     in   1           port A write enable
//   addra   in   ADDR_WIDTH  port A address (write and readback)
//   addrb   in   ADDR_WIDTH  port B read address
//   dia     in   DATA_WIDTH  port A write data
//   doa     out  DATA_WIDTH  port A registered read data (write-first)
//   dob     out  DATA_WIDTH  port B registered read data (write-first bypass)
// ----------------------------------------------------------------------------
module fifo_dpram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dia,
    output logic [DATA_WIDTH-1:0] doa,
    output logic [DATA_WIDTH-1:0] dob
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage is deliberately left out of reset so that it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] doa_p1;
    logic [DATA_WIDTH-1:0] dob_p1;

    // A same-cycle write to the port B read address must win.
    // Otherwise a word pushed into an empty FIFO would come out stale.
    logic                  collide_p0;
    logic [DATA_WIDTH-1:0] doa_nxt_p0;
    logic [DATA_WIDTH-1:0] dob_nxt_p0;

    always_comb begin
        collide_p0 = wea && (addra == addrb);
        doa_nxt_p0 = wea ? dia : mem[addra];
        dob_nxt_p0 = collide_p0 ? dia : mem[addrb];
    end

    // ---- stage p0 -> p1: array write (reset blocks it, contents kept) ----
    always_ff @(posedge clk) begin
        if (resetb && wea) begin
            mem[addra] <= dia;
        end
    end

    // ---- stage p0 -> p1: registered read ports ----
    always_ff @(posedge clk) begin
        if (!resetb) begin
            doa_p1 <= '0;
            dob_p1 <= '0;
        end else begin
            doa_p1 <= doa_nxt_p0;
            dob_p1 <= dob_nxt_p0;
        end
    end

    assign doa = doa_p1;
    assign dob = dob_p1;

endmodule

// File: tb/tb_fifo_dpram.sv
// ----------------------------------------------------------------------------
// tb_fifo_dpram
//
// Directed bench for fifo_dpram.
//
// Each record drives one clock cycle of inputs. The outputs registered on
// that edge are compared against the record's hand-computed values.
// Hand-written sequences follow the table. They cover FIFO-style streaming
// with pointer wrap, and a reset pulse in the middle of operation.
// ----------------------------------------------------------------------------
module tb_fifo_dpram;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          resetb;
    logic          wea;
    logic [AW-1:0] addra;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dia;
    logic [DW-1:0] doa;
    logic [DW-1:0] dob;

    int n_checks;
    int n_pass;

    typedef struct {
        logic          resetb;
        logic          wea;
        logic [AW-1:0] addra;
        logic [AW-1:0] addrb;
        logic [DW-1:0] dia;
        logic          chk_a;
        logic [DW-1:0] exp_a;
        logic          chk_b;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t tbl[$];

    fifo_dpram #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .wea    (wea),
        .addra  (addra),
        .addrb  (addrb),
        .dia    (dia),
        .doa    (doa),
        .dob    (dob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rb, input logic we,
                                input int aa, input int ab, input int d,
                                input logic ca, input int ea,
                                input logic cb, input int eb);
        vec_t v;
        v.resetb = rb;
        v.wea    = we;
        v.addra  = AW'(aa);
        v.addrb  = AW'(ab);
        v.dia    = DW'(d);
        v.chk_a  = ca;
        v.exp_a  = DW'(ea);
        v.chk_b  = cb;
        v.exp_b  = DW'(eb);
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample just after the edge.
    task automatic cycle(input logic rb, input logic we, input int aa,
                         input int ab, input int d);
        @(negedge clk);
        resetb = rb;
        wea    = we;
        addra  = AW'(aa);
        addrb  = AW'(ab);
        dia    = DW'(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        resetb   = 1'b0;
        wea      = 1'b0;
        addra    = '0;
        addrb    = '0;
        dia      = '0;

        // Reset held two cycles with a write presented: both outputs zero.
        tbl.push_back(mk(0, 1, 3, 3, 'hAA, 1, 'h00, 1, 'h00));
        tbl.push_back(mk(0, 1, 3, 3, 'hAA, 1, 'h00, 1, 'h00));
        // Basic writes. doa follows the write data.
        tbl.push_back(mk(1, 1, 0,  0, 'h11, 1, 'h11, 1, 'h11));
        tbl.push_back(mk(1, 1, 1,  0, 'h22, 1, 'h22, 1, 'h11));
        tbl.push_back(mk(1, 1, 15, 0, 'hFF, 1, 'hFF, 1, 'h11));
        // Port B reads with one cycle of latency. Port A reads back addr 1.
        tbl.push_back(mk(1, 0, 1,  1,  'h00, 1, 'h22, 1, 'h22));
        tbl.push_back(mk(1, 0, 15, 15, 'h00, 1, 'hFF, 1, 'hFF));
        tbl.push_back(mk(1, 0, 0,  0,  'h00, 1, 'h11, 1, 'h11));
        // Collision: mem[5]=33, then write 5C to 5 while reading 5.
        tbl.push_back(mk(1, 1, 5, 0, 'h33, 1, 'h33, 1, 'h11));
        tbl.push_back(mk(1, 1, 5, 5, 'h5C, 1, 'h5C, 1, 'h5C));
        tbl.push_back(mk(1, 0, 0, 5, 'h00, 1, 'h11, 1, 'h5C));
        // A write to another address must not disturb the port B read.
        tbl.push_back(mk(1, 1, 6, 5, 'h66, 1, 'h66, 1, 'h5C));
        tbl.push_back(mk(1, 0, 6, 6, 'h00, 1, 'h66, 1, 'h66));
        // Port A readback of addr 1, then a write-first readback.
        tbl.push_back(mk(1, 0, 1, 6, 'h00, 1, 'h22, 1, 'h66));
        tbl.push_back(mk(1, 1, 2, 1, 'h77, 1, 'h77, 1, 'h22));
        tbl.push_back(mk(1, 0, 2, 2, 'h00, 1, 'h77, 1, 'h77));

        foreach (tbl[i]) begin
            cycle(tbl[i].resetb, tbl[i].wea, int'(tbl[i].addra),
                  int'(tbl[i].addrb), int'(tbl[i].dia));
            if (tbl[i].chk_a) check($sformatf("vec%0d_doa", i), doa, tbl[i].exp_a);
            if (tbl[i].chk_b) check($sformatf("vec%0d_dob", i), dob, tbl[i].exp_b);
        end

        // Streaming: write 0x00..0x0F to addr 0..15 with the read pointer two
        // behind. At step 16 write addr 0 again with 0x10 (pointer wrap).
        for (int i = 0; i < 18; i++) begin
            cycle(1, (i <= 16), (i % 16), (i >= 2) ? (i - 2) : 0,
                  (i == 16) ? 'h10 : i);
            if (i >= 2) check($sformatf("stream%0d_dob", i), dob, DW'(i - 2));
        end
        cycle(1, 0, 0, 0, 0);
        check("wrap_dob", dob, 8'h10);
        check("wrap_doa", doa, 8'h10);

        // Mid-operation reset with a write that must be dropped.
        for (int i = 0; i < 4; i++) cycle(1, 1, i, 0, 'h40 + i);
        cycle(0, 1, 2, 2, 'hEE);
        check("midrst_dob", dob, 8'h00);
        check("midrst_doa", doa, 8'h00);
        cycle(1, 0, 2, 2, 0);
        check("retain_dob", dob, 8'h42);
        check("retain_doa", doa, 8'h42);
        cycle(1, 0, 3, 1, 0);
        check("retain1_dob", dob, 8'h41);
        check("retain3_doa", doa, 8'h43);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
